// File: rtl/button_event.sv
// Decodes a debounced, synchronous button level into single-cycle gesture events:
// press, release, click, double-click, long-press and auto-repeat.
module button_event #(
    parameter bit          ACTIVE_HIGH   = 1'b1,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned LONG_CYCLES   = 25000000,
    parameter int unsigned DCLICK_CYCLES = 12500000,
    parameter int unsigned REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic dclick_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic btn_held
);

    typedef enum logic [2:0] {
        StIdle,
        StPress1,
        StWait2,
        StPress2,
        StLong
    } state_e;

    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DclickLast = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepLast    = CNT_W'(REPEAT_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             btn_q;
    logic             pressed;
    logic             rise;
    logic             fall;

    assign pressed  = ACTIVE_HIGH ? btn_level : ~btn_level;
    assign rise     = pressed & ~btn_q;
    assign fall     = ~pressed & btn_q;
    assign btn_held = btn_q;

    // Edges are tested before timeouts so an edge always wins a same-cycle tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            btn_q         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            dclick_pulse  <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            btn_q         <= pressed;
            press_pulse   <= rise;
            release_pulse <= fall;
            click_pulse   <= 1'b0;
            dclick_pulse  <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            cnt_q         <= cnt_q + 1'b1;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (rise) begin
                        state_q <= StPress1;
                    end
                end
                StPress1: begin
                    if (fall) begin
                        state_q <= StWait2;
                        cnt_q   <= '0;
                    end else if (cnt_q == LongLast) begin
                        long_pulse <= 1'b1;
                        state_q    <= StLong;
                        cnt_q      <= '0;
                    end
                end
                StWait2: begin
                    if (rise) begin
                        state_q <= StPress2;
                        cnt_q   <= '0;
                    end else if (cnt_q == DclickLast) begin
                        click_pulse <= 1'b1;
                        state_q     <= StIdle;
                        cnt_q       <= '0;
                    end
                end
                StPress2: begin
                    if (fall) begin
                        dclick_pulse <= 1'b1;
                        state_q      <= StIdle;
                        cnt_q        <= '0;
                    end else if (cnt_q == LongLast) begin
                        long_pulse <= 1'b1;
                        state_q    <= StLong;
                        cnt_q      <= '0;
                    end
                end
                StLong: begin
                    if (fall) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == RepLast) begin
                        repeat_pulse <= 1'b1;
                        cnt_q        <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: vector table, directed gesture sequences and random
// level traffic compared against a timestamp-based gesture model.
module tb_button_event;

    localparam int LONG = 20;
    localparam int DCLK = 10;
    localparam int REP  = 5;

    localparam int PhIdle   = 0;
    localparam int PhHeld   = 1;
    localparam int PhGap    = 2;
    localparam int PhSecond = 3;
    localparam int PhLong   = 4;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic btn_level = 1'b0;
    logic btn_n_level = 1'b1;

    logic press_a, release_a, click_a, dclick_a, long_a, repeat_a, held_a;
    logic press_n, release_n, click_n, dclick_n, long_n, repeat_n, held_n;
    logic [6:0] vec_a;
    logic [6:0] vec_n;
    logic [6:0] cur;

    // Vector bit order: press, release, click, dclick, long, repeat, held.
    assign vec_a = {press_a, release_a, click_a, dclick_a, long_a, repeat_a, held_a};
    assign vec_n = {press_n, release_n, click_n, dclick_n, long_n, repeat_n, held_n};

    always #5 clk = ~clk;

    button_event #(
        .ACTIVE_HIGH  (1'b1),
        .CNT_W        (16),
        .LONG_CYCLES  (LONG),
        .DCLICK_CYCLES(DCLK),
        .REPEAT_CYCLES(REP)
    ) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .btn_level    (btn_level),
        .press_pulse  (press_a),
        .release_pulse(release_a),
        .click_pulse  (click_a),
        .dclick_pulse (dclick_a),
        .long_pulse   (long_a),
        .repeat_pulse (repeat_a),
        .btn_held     (held_a)
    );

    button_event #(
        .ACTIVE_HIGH  (1'b0),
        .CNT_W        (16),
        .LONG_CYCLES  (LONG),
        .DCLICK_CYCLES(DCLK),
        .REPEAT_CYCLES(REP)
    ) u_dut_n (
        .clk          (clk),
        .rstn         (rstn),
        .btn_level    (btn_n_level),
        .press_pulse  (press_n),
        .release_pulse(release_n),
        .click_pulse  (click_n),
        .dclick_pulse (dclick_n),
        .long_pulse   (long_n),
        .repeat_pulse (repeat_n),
        .btn_held     (held_n)
    );

    int tests = 0;
    int fails = 0;
    int n_press, n_rel, n_click, n_dclick, n_long, n_rep;

    // Gesture model: phase plus the edge index at which it began.
    int m_phase, m_t0, m_n;
    bit m_prev;
    logic [6:0] m_exp;

    typedef struct {
        bit         btn;
        logic [6:0] exp;
    } vec_t;
    vec_t tbl[18];

    task automatic model_reset();
        m_phase = PhIdle;
        m_t0    = 0;
        m_n     = 0;
        m_prev  = 1'b0;
        m_exp   = '0;
    endtask

    task automatic model_step(input bit p);
        bit rise, fall, ev_click, ev_dclick, ev_long, ev_rep;
        int age;
        m_n++;
        rise = p && !m_prev;
        fall = !p && m_prev;
        age  = m_n - m_t0;
        ev_click = 0; ev_dclick = 0; ev_long = 0; ev_rep = 0;
        case (m_phase)
            PhIdle: if (rise) begin m_phase = PhHeld; m_t0 = m_n; end
            PhHeld: begin
                if (fall) begin m_phase = PhGap; m_t0 = m_n; end
                else if (age == LONG) begin ev_long = 1; m_phase = PhLong; m_t0 = m_n; end
            end
            PhGap: begin
                if (rise) begin m_phase = PhSecond; m_t0 = m_n; end
                else if (age == DCLK) begin ev_click = 1; m_phase = PhIdle; end
            end
            PhSecond: begin
                if (fall) begin ev_dclick = 1; m_phase = PhIdle; end
                else if (age == LONG) begin ev_long = 1; m_phase = PhLong; m_t0 = m_n; end
            end
            default: begin
                if (fall) m_phase = PhIdle;
                else if (age % REP == 0) ev_rep = 1;
            end
        endcase
        m_exp  = {rise, fall, ev_click, ev_dclick, ev_long, ev_rep, p};
        m_prev = p;
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_press = 0; n_rel = 0; n_click = 0; n_dclick = 0; n_long = 0; n_rep = 0;
    endtask

    // One clock: drive the logical level b (inverted onto the low-active DUT when inv).
    task automatic apply(input bit b, input bit inv, input string name);
        if (inv) begin
            btn_n_level = ~b;
            btn_level   = 1'b0;
        end else begin
            btn_level   = b;
            btn_n_level = 1'b1;
        end
        @(posedge clk);
        #1;
        model_step(b);
        cur = inv ? vec_n : vec_a;
        n_press  += int'(cur[6]);
        n_rel    += int'(cur[5]);
        n_click  += int'(cur[4]);
        n_dclick += int'(cur[3]);
        n_long   += int'(cur[2]);
        n_rep    += int'(cur[1]);
        check(name, cur, m_exp);
    endtask

    task automatic apply_n(input bit b, input int n, input bit inv, input string name);
        for (int i = 0; i < n; i++) apply(b, inv, name);
    endtask

    task automatic do_reset(input bit b);
        rstn        = 1'b0;
        btn_level   = b;
        btn_n_level = 1'b1;
        #2;
        check("reset_async", vec_a, 7'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", vec_a, 7'b0);
        check("reset_hold_n", vec_n, 7'b0);
        model_reset();
        rstn = 1'b1;
    endtask

    initial begin
        bit lvl;
        int len;
        int total;

        tbl[0] = '{1'b0, 7'b0000000};
        tbl[1] = '{1'b1, 7'b1000001};
        for (int i = 2; i <= 5; i++) tbl[i] = '{1'b1, 7'b0000001};
        tbl[6] = '{1'b0, 7'b0100000};
        for (int i = 7; i <= 15; i++) tbl[i] = '{1'b0, 7'b0000000};
        tbl[16] = '{1'b0, 7'b0010000};
        tbl[17] = '{1'b0, 7'b0000000};

        model_reset();
        clear_counts();
        #1;

        // Reset with the button already down: press fires on the first clock after release.
        do_reset(1'b1);
        apply(1'b1, 1'b0, "rst_release");
        check("rst_press", cur, 7'b1000001);
        apply_n(1'b1, 2, 1'b0, "rst_hold");
        apply_n(1'b0, DCLK + 3, 1'b0, "rst_tail");

        // Short click from the vector table.
        do_reset(1'b0);
        clear_counts();
        foreach (tbl[i]) begin
            apply(tbl[i].btn, 1'b0, "tbl_model");
            check("tbl_vec", cur, tbl[i].exp);
        end
        check_int("click_dclick_cnt", n_dclick + n_long + n_rep, 0);

        // Double click.
        clear_counts();
        apply_n(1'b1, 5, 1'b0, "dc");
        apply_n(1'b0, 4, 1'b0, "dc");
        apply_n(1'b1, 5, 1'b0, "dc");
        apply(1'b0, 1'b0, "dc");
        check("dc_edge", cur, 7'b0101000);
        apply_n(1'b0, DCLK + 5, 1'b0, "dc_tail");
        check_int("dc_dclick_cnt", n_dclick, 1);
        check_int("dc_click_cnt", n_click, 0);

        // Long hold: 41 held edges give long plus (41-1-LONG)/REP repeats.
        clear_counts();
        apply_n(1'b1, 41, 1'b0, "long");
        apply(1'b0, 1'b0, "long");
        check("long_release", cur, 7'b0100000);
        apply_n(1'b0, DCLK + 5, 1'b0, "long_tail");
        check_int("long_cnt", n_long, 1);
        check_int("long_rep_cnt", n_rep, (41 - 1 - LONG) / REP);
        check_int("long_click_cnt", n_click + n_dclick, 0);

        // Release on the long-threshold cycle: edge wins, click follows.
        clear_counts();
        apply_n(1'b1, LONG, 1'b0, "bnd_long");
        apply(1'b0, 1'b0, "bnd_long");
        check("bnd_long_edge", cur, 7'b0100000);
        apply_n(1'b0, DCLK + 2, 1'b0, "bnd_long_tail");
        check_int("bnd_long_cnt", n_long, 0);
        check_int("bnd_long_click", n_click, 1);

        // Second press on the click-timeout cycle: edge wins, double click follows.
        clear_counts();
        apply_n(1'b1, 3, 1'b0, "bnd_dc");
        apply_n(1'b0, DCLK, 1'b0, "bnd_dc");
        apply(1'b1, 1'b0, "bnd_dc");
        check("bnd_dc_press", cur, 7'b1000001);
        apply_n(1'b1, 2, 1'b0, "bnd_dc");
        apply(1'b0, 1'b0, "bnd_dc");
        check("bnd_dc_edge", cur, 7'b0101000);
        apply_n(1'b0, DCLK + 2, 1'b0, "bnd_dc_tail");
        check_int("bnd_dc_click", n_click, 0);

        // Active-low instance: short low pulse gives the same click.
        clear_counts();
        apply_n(1'b1, 5, 1'b1, "pol");
        apply_n(1'b0, DCLK + 3, 1'b1, "pol");
        check_int("pol_press", n_press, 1);
        check_int("pol_release", n_rel, 1);
        check_int("pol_click", n_click, 1);

        // Reset in the click window discards the pending click.
        apply_n(1'b1, 4, 1'b0, "rst_mid");
        apply_n(1'b0, 3, 1'b0, "rst_mid");
        clear_counts();
        do_reset(1'b0);
        apply_n(1'b0, DCLK + 15, 1'b0, "rst_mid_tail");
        check_int("rst_mid_click", n_click, 0);

        // Random level traffic against the model.
        total = 0;
        lvl   = 1'b0;
        while (total < 2500) begin
            lvl = ~lvl;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(LONG - 5, 50)
                                               : $urandom_range(1, DCLK + 2);
            apply_n(lvl, len, 1'b0, "rand");
            total += len;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Consumes the clean, synchronous level from the button debouncer and decodes it into single-cycle event pulses: press, release, click, double-click, long-press and auto-repeat.
- Sits between the debounce stage and the control FSMs (menu/mode logic), so every consumer sees the same decoded events.
- Input is already debounced and synchronous, so the block adds no synchronizer and no filtering.

Parameters:
- ACTIVE_HIGH, 1: 1 = btn_level high means pressed; 0 = btn_level is inverted internally before all logic.
- CNT_W, 32: width of the internal cycle counter.
- LONG_CYCLES, 25000000: held cycles before long_pulse (0.5 s at 50 MHz).
- DCLICK_CYCLES, 12500000: window after a short release in which a second press makes a double-click.
- REPEAT_CYCLES, 5000000: period of repeat_pulse while in long-hold.
- Legal values: all *_CYCLES must be >= 2 and < 2**CNT_W. Behaviour outside this range is undefined.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- btn_level  in  1  debounced button level
- press_pulse  out  1  one cycle per press edge
- release_pulse  out  1  one cycle per release edge
- click_pulse  out  1  single short click confirmed
- dclick_pulse  out  1  double click confirmed
- long_pulse  out  1  long-press threshold reached
- repeat_pulse  out  1  auto-repeat tick during long hold
- btn_held  out  1  registered pressed level (polarity-corrected)

Behaviour:
- Reset (async, rstn low): all outputs 0, btn_q=0, cnt=0, state=IDLE. Deassertion takes effect on the next clk edge. Reset mid-gesture discards it; no pending event fires.
- Edge detect:
  - p = ACTIVE_HIGH ? btn_level : ~btn_level; btn_q <= p every cycle; btn_held = btn_q.
  - rise = p & ~btn_q; fall = ~p & btn_q.
- All event outputs are registered, one clk cycle wide, and asserted the cycle after the edge at which the condition is evaluated.
- press_pulse follows every rise and release_pulse every fall, regardless of state.
- cnt resets to 0 on every state entry and increments by 1 each cycle within the state. A timeout is cnt == X-1.
- States and transitions:
  - IDLE: rise -> PRESS1.
  - PRESS1: fall -> WAIT2. Else timeout LONG_CYCLES -> long_pulse, LONG.
  - WAIT2: rise -> PRESS2. Else timeout DCLICK_CYCLES -> click_pulse, IDLE.
  - PRESS2: fall -> dclick_pulse, IDLE. Else timeout LONG_CYCLES -> long_pulse, LONG (no dclick).
  - LONG: fall -> IDLE (no click). Else at cnt == REPEAT_CYCLES-1 -> repeat_pulse, cnt <= 0, stay in LONG.
- Priority: an edge always beats a timeout in the same cycle.
  - PRESS1 fall on the long-threshold cycle: go to WAIT2, no long_pulse.
  - WAIT2 rise on the timeout cycle: go to PRESS2, no click_pulse.
- A third press after a double-click starts a fresh gesture from IDLE.
- Counter never wraps outside LONG, because legal parameters force a state exit first.
- Events are mutually exclusive per cycle, except press/release_pulse coinciding with dclick_pulse (release, same cycle).

Test Plan (LONG_CYCLES=20, DCLICK_CYCLES=10, REPEAT_CYCLES=5, ACTIVE_HIGH=1):
- Reset: rstn low while btn_level=1 -> all outputs 0. Release rstn with btn_level=1 -> press_pulse one cycle later, then FSM in PRESS1.
- Short click: press 5 cycles, release, idle -> press_pulse, release_pulse, then click_pulse exactly 10 cycles after the release-detect cycle. No dclick, long or repeat pulses.
- Double click: press 5, release 4, press 5, release -> dclick_pulse on the cycle of the second release_pulse. No click_pulse at any point.
- Long hold: hold 40 cycles -> long_pulse at 20 held cycles, repeat_pulse every 5 cycles thereafter (4 pulses), release -> release_pulse only.
- Boundary: release on exactly the 20th held cycle -> no long_pulse, click follows. Second press on exactly the 10th WAIT2 cycle -> no click, PRESS2 entered.
- Polarity and async reset: ACTIVE_HIGH=0 short low pulse -> same click sequence. Assert rstn mid-WAIT2 -> no click_pulse ever appears.
